// File: rtl/xres_reset_sequencer.sv
// ---------------------------------------------------------------------------
// xres_reset_sequencer
//
// Purpose:
//   Takes the level-shifted xres pad reset and releases the chip's digital
//   reset domains in a fixed order: clocking, housekeeping, management core,
//   user project. Deassertion of resetb is synchronised to `clock`. Every
//   domain stays in reset for a minimum time after the synchronised release
//   or after a software reset request. Successive domains are then released
//   STAGE_DLY cycles apart.
//
// Parameters:
//   SYNC_STAGES  flops in the resetb deassertion synchronizer (>= 2)
//   MIN_ASSERT   cycles all resets stay asserted after release / soft reset
//   STAGE_DLY    cycles between successive domain releases
//
// Ports:
//   clock         in   core clock
//   resetb        in   async active-low reset from the xres buffer
//   sw_rst_req    in   synchronous soft-reset request (level) from housekeeping
//   user_rst_req  in   user-domain-only reset request (USER_RST_CTRL_EN only)
//   rstn_clk      out  active-low reset to the clocking block
//   rstn_hk       out  active-low reset to housekeeping
//   rstn_core     out  active-low reset to the management core
//   rstn_user     out  active-low reset to the user project
//   rst_done      out  high once every domain has been released
//   seq_state     out  current sequencer state, for debug readback
//
// Build option:
//   USER_RST_CTRL_EN  adds user_rst_req and the UREL state (7), which lets
//                     the user domain be reset on its own while the rest of
//                     the chip keeps running.
// ---------------------------------------------------------------------------
module xres_reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_ASSERT  = 32,
  parameter int STAGE_DLY   = 16
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       sw_rst_req,
`ifdef USER_RST_CTRL_EN
  input  logic       user_rst_req,
`endif
  output logic       rstn_clk,
  output logic       rstn_hk,
  output logic       rstn_core,
  output logic       rstn_user,
  output logic       rst_done,
  output logic [2:0] seq_state
);

  localparam int CNT_MAX = (MIN_ASSERT > STAGE_DLY) ? MIN_ASSERT : STAGE_DLY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // The edge that leaves HOLD already counts as the first assertion cycle
  // after the release condition was seen. WAIT therefore needs one cycle
  // fewer than MIN_ASSERT. The counter also starts at zero, so the last
  // count is MIN_ASSERT-2.
  localparam logic [CNT_W-1:0] WAIT_LAST  =
    CNT_W'((MIN_ASSERT > 2) ? (MIN_ASSERT - 2) : 0);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);

  typedef enum logic [2:0] {
    ST_HOLD     = 3'd0,
    ST_WAIT     = 3'd1,
    ST_REL_CLK  = 3'd2,
    ST_REL_HK   = 3'd3,
    ST_REL_CORE = 3'd4,
    ST_REL_USER = 3'd5,
    ST_RUN      = 3'd6
`ifdef USER_RST_CTRL_EN
    , ST_UREL   = 3'd7
`endif
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_sync;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                   clk_d, hk_d, core_d, user_d, done_d;

  // Deassertion synchronizer. The chain clears at once when resetb falls.
  // It then shifts in ones, so rst_sync rises SYNC_STAGES edges after the
  // pad reset is released. Assertion stays fully asynchronous.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync = sync_q[SYNC_STAGES-1];

  // The shared delay counter saturates instead of wrapping. A stuck state
  // therefore can never alias back into an early release.
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  // State, counter and reset outputs are all registered here. This keeps
  // the rstn_* lines glitch-free, with no combinational path from any input.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q   <= ST_HOLD;
      cnt_q     <= '0;
      rstn_clk  <= 1'b0;
      rstn_hk   <= 1'b0;
      rstn_core <= 1'b0;
      rstn_user <= 1'b0;
      rst_done  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rstn_clk  <= clk_d;
      rstn_hk   <= hk_d;
      rstn_core <= core_d;
      rstn_user <= user_d;
      rst_done  <= done_d;
    end
  end

  // Next-state and next-output logic. By default everything holds its value
  // and the counter advances. A soft-reset request is checked before the
  // state decode, so it beats any release due on the same edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    clk_d   = rstn_clk;
    hk_d    = rstn_hk;
    core_d  = rstn_core;
    user_d  = rstn_user;
    done_d  = rst_done;

    if (sw_rst_req) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      clk_d   = 1'b0;
      hk_d    = 1'b0;
      core_d  = 1'b0;
      user_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          cnt_d  = '0;
          clk_d  = 1'b0;
          hk_d   = 1'b0;
          core_d = 1'b0;
          user_d = 1'b0;
          done_d = 1'b0;
          if (rst_sync) begin
            state_d = ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (cnt_q >= WAIT_LAST) begin
            clk_d   = 1'b1;
            state_d = ST_REL_CLK;
            cnt_d   = '0;
          end
        end

        ST_REL_CLK: begin
          if (cnt_q >= STAGE_LAST) begin
            hk_d    = 1'b1;
            state_d = ST_REL_HK;
            cnt_d   = '0;
          end
        end

        ST_REL_HK: begin
          if (cnt_q >= STAGE_LAST) begin
            core_d  = 1'b1;
            state_d = ST_REL_CORE;
            cnt_d   = '0;
          end
        end

        ST_REL_CORE: begin
          if (cnt_q >= STAGE_LAST) begin
            user_d  = 1'b1;
            done_d  = 1'b1;
            state_d = ST_REL_USER;
            cnt_d   = '0;
          end
        end

        // One settling cycle after the user release, then steady state.
        ST_REL_USER: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end

        ST_RUN: begin
          cnt_d = '0;
`ifdef USER_RST_CTRL_EN
          if (user_rst_req) begin
            user_d  = 1'b0;
            done_d  = 1'b0;
            state_d = ST_UREL;
          end
`endif
        end

`ifdef USER_RST_CTRL_EN
        // User-only reset. Hold here while the request is high. Once it
        // drops, wait one stage delay before releasing the user domain.
        ST_UREL: begin
          if (user_rst_req) begin
            cnt_d = '0;
          end else if (cnt_q >= STAGE_LAST) begin
            user_d  = 1'b1;
            done_d  = 1'b1;
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
`endif

        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          clk_d   = 1'b0;
          hk_d    = 1'b0;
          core_d  = 1'b0;
          user_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  assign seq_state = state_q;

endmodule

// File: tb/tb_xres_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_xres_reset_sequencer
//
// Self-checking bench for xres_reset_sequencer with default parameters.
// A behavioural model tracks "edges since the sequence started". Each
// output is derived from that number and the release offsets. The model is
// stepped alongside the DUT, and every output is compared on the falling
// clock edge.
// ---------------------------------------------------------------------------
module tb_xres_reset_sequencer;

  localparam int SYNC_STAGES = 2;
  localparam int MIN_ASSERT  = 32;
  localparam int STAGE_DLY   = 16;

  // Release offsets, in edges after the edge that leaves reset hold.
  localparam int T_CLK  = MIN_ASSERT - 1;
  localparam int T_HK   = T_CLK + STAGE_DLY;
  localparam int T_CORE = T_HK + STAGE_DLY;
  localparam int T_USER = T_CORE + STAGE_DLY;
  localparam int T_RUN  = T_USER + 1;

  // Absolute edge numbers after resetb rises (edge 1 = first edge).
  localparam int E_CLK  = SYNC_STAGES + MIN_ASSERT;
  localparam int E_HK   = E_CLK + STAGE_DLY;
  localparam int E_CORE = E_HK + STAGE_DLY;
  localparam int E_USER = E_CORE + STAGE_DLY;

  logic       clock = 1'b0;
  logic       resetb = 1'b1;
  logic       sw_rst_req = 1'b0;
`ifdef USER_RST_CTRL_EN
  logic       user_rst_req = 1'b0;
`endif
  logic       rstn_clk, rstn_hk, rstn_core, rstn_user, rst_done;
  logic [2:0] seq_state;
  logic [7:0] act_vec;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  int m_hi   = 0;
  bit m_seq  = 1'b0;
  int m_e    = 0;
  bit m_user = 1'b0;
  int m_ulow = 0;
  int edge_n = 0;

  xres_reset_sequencer #(
    .SYNC_STAGES(SYNC_STAGES),
    .MIN_ASSERT (MIN_ASSERT),
    .STAGE_DLY  (STAGE_DLY)
  ) dut (
    .clock       (clock),
    .resetb      (resetb),
    .sw_rst_req  (sw_rst_req),
`ifdef USER_RST_CTRL_EN
    .user_rst_req(user_rst_req),
`endif
    .rstn_clk    (rstn_clk),
    .rstn_hk     (rstn_hk),
    .rstn_core   (rstn_core),
    .rstn_user   (rstn_user),
    .rst_done    (rst_done),
    .seq_state   (seq_state)
  );

  always #5 clock = ~clock;

  assign act_vec = {rstn_clk, rstn_hk, rstn_core, rstn_user, rst_done, seq_state};

  // Model: asynchronous pad reset clears everything immediately.
  task automatic model_async_reset();
    m_hi   = 0;
    m_seq  = 1'b0;
    m_e    = 0;
    m_user = 1'b0;
    m_ulow = 0;
  endtask

  // Model: one rising clock edge, using the inputs the DUT just sampled.
  task automatic model_edge();
`ifdef USER_RST_CTRL_EN
    bit run_before;
    run_before = m_seq && (m_e >= T_RUN) && !m_user;
`endif
    if (!resetb) begin
      model_async_reset();
      return;
    end
    if (sw_rst_req) begin
      m_seq  = 1'b0;
      m_user = 1'b0;
    end else if (!m_seq) begin
      if (m_hi >= SYNC_STAGES) begin
        m_seq = 1'b1;
        m_e   = 0;
      end
    end else begin
      if (m_e < 1000000) m_e++;
`ifdef USER_RST_CTRL_EN
      if (m_user) begin
        if (user_rst_req) begin
          m_ulow = 0;
        end else begin
          m_ulow++;
          if (m_ulow >= STAGE_DLY) m_user = 1'b0;
        end
      end else if (run_before && user_rst_req) begin
        m_user = 1'b1;
        m_ulow = 0;
      end
`endif
    end
    if (m_hi < 1000000) m_hi++;
  endtask

  // Expected {rstn_clk, rstn_hk, rstn_core, rstn_user, rst_done, state}.
  function automatic logic [7:0] exp_vec();
    logic [7:0] v;
    v = 8'h00;
    if (m_seq) begin
      v[7] = (m_e >= T_CLK);
      v[6] = (m_e >= T_HK);
      v[5] = (m_e >= T_CORE);
      v[4] = (m_e >= T_USER) && !m_user;
      v[3] = (m_e >= T_USER) && !m_user;
      if (m_user)            v[2:0] = 3'd7;
      else if (m_e < T_CLK)  v[2:0] = 3'd1;
      else if (m_e < T_HK)   v[2:0] = 3'd2;
      else if (m_e < T_CORE) v[2:0] = 3'd3;
      else if (m_e < T_USER) v[2:0] = 3'd4;
      else if (m_e == T_USER) v[2:0] = 3'd5;
      else                   v[2:0] = 3'd6;
    end
    return v;
  endfunction

  // Advance one clock: DUT and model see the same edge; we end on negedge.
  task automatic tick();
    @(posedge clock);
    model_edge();
    edge_n++;
    @(negedge clock);
  endtask

  task automatic test_reset();
    #1 resetb = 1'b0;
    model_async_reset();
    #1;
    vectors++;
    if (act_vec !== exp_vec()) begin
      miscompares++;
      $display("[TB] FAIL reset_async @%0t: got %b, expected %b", $time, act_vec, exp_vec());
    end
    @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (act_vec !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL reset_hold @%0t: got %b, expected %b", $time, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_powerup();
    int f_clk, f_hk, f_core, f_user, f_done;
    f_clk = -1; f_hk = -1; f_core = -1; f_user = -1; f_done = -1;
    #2 resetb = 1'b1;
    edge_n = 0;
    for (int i = 0; i < 90; i++) begin
      tick();
      vectors++;
      if (act_vec !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL powerup @%0t edge %0d: got %b, expected %b", $time, edge_n, act_vec, exp_vec());
      end
      if (rstn_clk  && f_clk  < 0) f_clk  = edge_n;
      if (rstn_hk   && f_hk   < 0) f_hk   = edge_n;
      if (rstn_core && f_core < 0) f_core = edge_n;
      if (rstn_user && f_user < 0) f_user = edge_n;
      if (rst_done  && f_done < 0) f_done = edge_n;
    end
    vectors++;
    if (f_clk !== E_CLK) begin
      miscompares++;
      $display("[TB] FAIL powerup_clk_edge: got %0d, expected %0d", f_clk, E_CLK);
    end
    vectors++;
    if (f_hk !== E_HK) begin
      miscompares++;
      $display("[TB] FAIL powerup_hk_edge: got %0d, expected %0d", f_hk, E_HK);
    end
    vectors++;
    if (f_core !== E_CORE) begin
      miscompares++;
      $display("[TB] FAIL powerup_core_edge: got %0d, expected %0d", f_core, E_CORE);
    end
    vectors++;
    if (f_user !== E_USER || f_done !== E_USER) begin
      miscompares++;
      $display("[TB] FAIL powerup_user_edge: got %0d/%0d, expected %0d", f_user, f_done, E_USER);
    end
    vectors++;
    if (seq_state !== 3'd6) begin
      miscompares++;
      $display("[TB] FAIL powerup_run: got %0d, expected 6", seq_state);
    end
  endtask

  task automatic test_async_run();
    int f_user;
    f_user = -1;
    #2 resetb = 1'b0;
    model_async_reset();
    #1;
    vectors++;
    if (act_vec !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL async_run_immediate @%0t: got %b, expected %b", $time, act_vec, 8'h00);
    end
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (act_vec !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL async_run_hold @%0t: got %b, expected %b", $time, act_vec, exp_vec());
      end
    end
    #2 resetb = 1'b1;
    edge_n = 0;
    for (int i = 0; i < 90; i++) begin
      tick();
      vectors++;
      if (act_vec !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL async_run_seq @%0t edge %0d: got %b, expected %b", $time, edge_n, act_vec, exp_vec());
      end
      if (rstn_user && f_user < 0) f_user = edge_n;
    end
    vectors++;
    if (f_user !== E_USER) begin
      miscompares++;
      $display("[TB] FAIL async_run_user_edge: got %0d, expected %0d", f_user, E_USER);
    end
  endtask

  task automatic test_soft_pulse();
    int f_clk;
    f_clk = -1;
    sw_rst_req = 1'b1;
    edge_n = 0;
    tick();
    sw_rst_req = 1'b0;
    vectors++;
    if (act_vec !== exp_vec() || act_vec !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL soft_pulse_drop @%0t: got %b, expected %b", $time, act_vec, 8'h00);
    end
    for (int i = 0; i < 90; i++) begin
      tick();
      vectors++;
      if (act_vec !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL soft_pulse_seq @%0t: got %b, expected %b", $time, act_vec, exp_vec());
      end
      if (rstn_clk && f_clk < 0) f_clk = edge_n;
    end
    // Edge 1 here sampled the pulse; rstn_clk follows MIN_ASSERT edges later.
    vectors++;
    if (f_clk !== 1 + T_CLK + 1) begin
      miscompares++;
      $display("[TB] FAIL soft_pulse_clk_edge: got %0d, expected %0d", f_clk, 1 + T_CLK + 1);
    end
  endtask

  task automatic test_soft_hold();
    // Re-enter the sequence and stop inside the housekeeping release window.
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    for (int i = 0; i < T_HK + 8; i++) tick();
    vectors++;
    if (seq_state !== 3'd3) begin
      miscompares++;
      $display("[TB] FAIL soft_hold_setup: got %0d, expected 3", seq_state);
    end
    sw_rst_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      vectors++;
      if (act_vec !== exp_vec() || act_vec !== 8'h00) begin
        miscompares++;
        $display("[TB] FAIL soft_hold_low @%0t: got %b, expected %b", $time, act_vec, 8'h00);
      end
    end
    sw_rst_req = 1'b0;
    for (int i = 0; i < 90; i++) begin
      tick();
      vectors++;
      if (act_vec !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL soft_hold_restart @%0t: got %b, expected %b", $time, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_glitch();
    int f_any;
    f_any = -1;
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    for (int i = 0; i < T_CORE + 6; i++) tick();
    vectors++;
    if (seq_state !== 3'd4) begin
      miscompares++;
      $display("[TB] FAIL glitch_setup: got %0d, expected 4", seq_state);
    end
    #2 resetb = 1'b0;
    model_async_reset();
    #1;
    vectors++;
    if (act_vec !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL glitch_immediate @%0t: got %b, expected %b", $time, act_vec, 8'h00);
    end
    @(negedge clock);
    #2 resetb = 1'b1;
    edge_n = 0;
    for (int i = 0; i < 90; i++) begin
      tick();
      vectors++;
      if (act_vec !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL glitch_seq @%0t: got %b, expected %b", $time, act_vec, exp_vec());
      end
      if (act_vec[7:3] != 5'b0 && f_any < 0) f_any = edge_n;
    end
    vectors++;
    if (f_any !== E_CLK) begin
      miscompares++;
      $display("[TB] FAIL glitch_first_release: got %0d, expected %0d", f_any, E_CLK);
    end
  endtask

`ifdef USER_RST_CTRL_EN
  task automatic test_user_ctrl();
    int f_user;
    f_user = -1;
    vectors++;
    if (seq_state !== 3'd6) begin
      miscompares++;
      $display("[TB] FAIL user_setup: got %0d, expected 6", seq_state);
    end
    user_rst_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (act_vec !== exp_vec() || act_vec !== 8'b11100_111) begin
        miscompares++;
        $display("[TB] FAIL user_hold @%0t: got %b, expected %b", $time, act_vec, 8'b11100_111);
      end
    end
    user_rst_req = 1'b0;
    edge_n = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      vectors++;
      if (act_vec !== exp_vec() || act_vec[7:5] !== 3'b111) begin
        miscompares++;
        $display("[TB] FAIL user_release @%0t: got %b, expected %b", $time, act_vec, exp_vec());
      end
      if (rstn_user && f_user < 0) f_user = edge_n;
    end
    vectors++;
    if (f_user !== STAGE_DLY) begin
      miscompares++;
      $display("[TB] FAIL user_release_edge: got %0d, expected %0d", f_user, STAGE_DLY);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      sw_rst_req = ($urandom_range(0, 127) == 0);
`ifdef USER_RST_CTRL_EN
      if ($urandom_range(0, 15) == 0) user_rst_req = ~user_rst_req;
`endif
      if ($urandom_range(0, 499) == 0) begin
        #2 resetb = 1'b0;
        model_async_reset();
        #1;
        vectors++;
        if (act_vec !== exp_vec()) begin
          miscompares++;
          $display("[TB] FAIL random_async @%0t: got %b, expected %b", $time, act_vec, exp_vec());
        end
        @(negedge clock);
        #2 resetb = 1'b1;
      end
      tick();
      vectors++;
      if (act_vec !== exp_vec()) begin
        miscompares++;
        $display("[TB] FAIL random @%0t: got %b, expected %b", $time, act_vec, exp_vec());
      end
    end
    sw_rst_req = 1'b0;
`ifdef USER_RST_CTRL_EN
    user_rst_req = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_async_run();
    test_soft_pulse();
    test_soft_hold();
    test_glitch();
`ifdef USER_RST_CTRL_EN
    test_user_ctrl();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
